// File: rtl/serdesphy_tx_pkg.sv
// Shared constants and FSM encoding for the 240 MHz TX word shifter.
package serdesphy_tx_pkg;

    localparam int         SERDESPHY_WORD_W     = 10;
    localparam logic [9:0] SERDESPHY_K28_5_RDN  = 10'h17C;
    localparam logic [6:0] SERDESPHY_PRBS7_SEED = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } tx_state_e;

endpackage

// File: rtl/serdesphy_tx_word_fifo.sv
// Single-clock word FIFO with wrap-bit pointers and combinational read port.
module serdesphy_tx_word_fifo #(
    parameter  int W     = 10,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk_240m_tx,
    input  logic         rst_n_240m_tx,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic         push_ok, pop_ok;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign level   = wptr_q - rptr_q;
    assign dout    = mem_q[rptr_q[AW-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d  = pop_ok  ? rptr_q + 1'b1 : rptr_q;

    always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
        if (!rst_n_240m_tx) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_240m_tx) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/serdesphy_tx_word_shifter.sv
// TX word FIFO + LSB-first bit shifter with IDLE_WORD fill on underrun.
// Optional PRBS7 source enabled by defining SERDESPHY_TX_PRBS_EN.
module serdesphy_tx_word_shifter
    import serdesphy_tx_pkg::*;
#(
    parameter  int                WORD_W      = SERDESPHY_WORD_W,
    parameter  int                FIFO_DEPTH  = 4,
    parameter  int                PRIME_LEVEL = 2,
    parameter  logic [WORD_W-1:0] IDLE_WORD   = SERDESPHY_K28_5_RDN,
    parameter  int                CNT_W       = 8,
    localparam int                LVL_W       = $clog2(FIFO_DEPTH) + 1,
    localparam int                BIT_W       = $clog2(WORD_W)
) (
    input  logic              clk_240m_tx,
    input  logic              rst_n_240m_tx,
    input  logic              tx_en,
    input  logic [WORD_W-1:0] word_in_data,
    input  logic              word_in_valid,
    output logic              word_in_ready,
    output logic              tx_serial_data,
    output logic              tx_serial_valid,
    output logic              tx_idle_pattern,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              busy,
    output logic              underrun_sticky,
    output logic [CNT_W-1:0]  underrun_count,
    input  logic              underrun_clr
`ifdef SERDESPHY_TX_PRBS_EN
    ,
    input  logic              prbs_en
`endif
);

    tx_state_e         state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              wvalid_q, wvalid_d, widle_q, widle_d, wprbs_q, wprbs_d;
    logic              sdata_q, sdata_d, svalid_q, svalid_d, sidle_q, sidle_d;
    logic              sticky_q, sticky_d, rdy_en_q;
    logic [CNT_W-1:0]  ucnt_q, ucnt_d;
    logic              push, pop, load, underrun, boundary, shifting;
    logic              fifo_full, fifo_empty, prbs_req, prbs_bit;
    logic [WORD_W-1:0] fifo_dout;

    // Ready stays low until the first clock after reset release.
    assign word_in_ready   = rdy_en_q && !fifo_full;
    assign push            = word_in_valid && word_in_ready;
    assign busy            = (state_q != ST_IDLE);
    assign boundary        = (bit_cnt_q == BIT_W'(WORD_W - 1));
    assign shifting        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign tx_serial_data  = sdata_q;
    assign tx_serial_valid = svalid_q;
    assign tx_idle_pattern = sidle_q;
    assign underrun_sticky = sticky_q;
    assign underrun_count  = ucnt_q;

    serdesphy_tx_word_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_240m_tx   (clk_240m_tx),
        .rst_n_240m_tx (rst_n_240m_tx),
        .push          (push),
        .pop           (pop),
        .din           (word_in_data),
        .dout          (fifo_dout),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .level         (fifo_level)
    );

`ifdef SERDESPHY_TX_PRBS_EN
    logic [6:0] lfsr_q, lfsr_d;

    assign prbs_req = prbs_en;
    assign prbs_bit = lfsr_q[6];

    always_comb begin
        lfsr_d = lfsr_q;
        if (shifting && wprbs_q) lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end

    always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
        if (!rst_n_240m_tx) lfsr_q <= SERDESPHY_PRBS7_SEED;
        else                lfsr_q <= lfsr_d;
    end
`else
    assign prbs_req = 1'b0;
    assign prbs_bit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        word_d    = word_q;
        wvalid_d  = wvalid_q;
        widle_d   = widle_q;
        wprbs_d   = wprbs_q;
        sdata_d   = 1'b0;
        svalid_d  = 1'b0;
        sidle_d   = 1'b0;
        load      = 1'b0;
        pop       = 1'b0;
        underrun  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (tx_en) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (!tx_en) state_d = ST_IDLE;
                else if (fifo_level >= LVL_W'(PRIME_LEVEL)) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                sdata_d   = wprbs_q ? prbs_bit : word_q[0];
                svalid_d  = wvalid_q;
                sidle_d   = widle_q;
                word_d    = word_q >> 1;
                bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
                // Disable on the last bit of a word ends immediately; otherwise drain.
                if (state_q == ST_RUN && tx_en) load = boundary;
                else if (boundary)              state_d = ST_IDLE;
                else                            state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            bit_cnt_d = '0;
            if (prbs_req) begin
                wprbs_d  = 1'b1;
                wvalid_d = 1'b1;
                widle_d  = 1'b0;
            end else if (!fifo_empty) begin
                pop      = 1'b1;
                word_d   = fifo_dout;
                wprbs_d  = 1'b0;
                wvalid_d = 1'b1;
                widle_d  = 1'b0;
            end else begin
                underrun = 1'b1;
                word_d   = IDLE_WORD;
                wprbs_d  = 1'b0;
                wvalid_d = 1'b0;
                widle_d  = 1'b1;
            end
        end
    end

    always_comb begin
        sticky_d = sticky_q;
        ucnt_d   = ucnt_q;
        if (underrun_clr) begin
            sticky_d = 1'b0;
            ucnt_d   = '0;
        end else if (underrun) begin
            sticky_d = 1'b1;
            if (ucnt_q != '1) ucnt_d = ucnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
        if (!rst_n_240m_tx) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            word_q    <= '0;
            wvalid_q  <= 1'b0;
            widle_q   <= 1'b0;
            wprbs_q   <= 1'b0;
            sdata_q   <= 1'b0;
            svalid_q  <= 1'b0;
            sidle_q   <= 1'b0;
            sticky_q  <= 1'b0;
            ucnt_q    <= '0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            word_q    <= word_d;
            wvalid_q  <= wvalid_d;
            widle_q   <= widle_d;
            wprbs_q   <= wprbs_d;
            sdata_q   <= sdata_d;
            svalid_q  <= svalid_d;
            sidle_q   <= sidle_d;
            sticky_q  <= sticky_d;
            ucnt_q    <= ucnt_d;
            rdy_en_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serdesphy_tx_word_shifter.sv
// Directed bench for serdesphy_tx_word_shifter (default build, PRIME_LEVEL=2).
module tb_serdesphy_tx_word_shifter;

    logic       clk_240m_tx   = 1'b0;
    logic       rst_n_240m_tx = 1'b1;
    logic       tx_en         = 1'b0;
    logic [9:0] word_in_data  = '0;
    logic       word_in_valid = 1'b0;
    logic       underrun_clr  = 1'b0;
    logic       word_in_ready, tx_serial_data, tx_serial_valid, tx_idle_pattern;
    logic       busy, underrun_sticky;
    logic [2:0] fifo_level;
    logic [7:0] underrun_count;

    int errors = 0;
    int checks = 0;

    logic [19:0] exp2;
    logic [9:0]  idlew, w1, w2;

    always #5 clk_240m_tx = ~clk_240m_tx;

    serdesphy_tx_word_shifter dut (
        .clk_240m_tx     (clk_240m_tx),
        .rst_n_240m_tx   (rst_n_240m_tx),
        .tx_en           (tx_en),
        .word_in_data    (word_in_data),
        .word_in_valid   (word_in_valid),
        .word_in_ready   (word_in_ready),
        .tx_serial_data  (tx_serial_data),
        .tx_serial_valid (tx_serial_valid),
        .tx_idle_pattern (tx_idle_pattern),
        .fifo_level      (fifo_level),
        .busy            (busy),
        .underrun_sticky (underrun_sticky),
        .underrun_count  (underrun_count),
        .underrun_clr    (underrun_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_240m_tx);
        #1;
    endtask

    task automatic push(input logic [9:0] w);
        word_in_valid = 1'b1;
        word_in_data  = w;
        step();
        word_in_valid = 1'b0;
    endtask

    initial begin
        exp2  = {10'h155, 10'h2AA};
        idlew = 10'h17C;
        w1    = 10'h0F3;
        w2    = 10'h2C1;

        // reset state
        rst_n_240m_tx = 1'b0;
        step(); step();
        chk("rst_data",   32'(tx_serial_data),  0);
        chk("rst_valid",  32'(tx_serial_valid), 0);
        chk("rst_idle",   32'(tx_idle_pattern), 0);
        chk("rst_ready",  32'(word_in_ready),   0);
        chk("rst_level",  32'(fifo_level),      0);
        chk("rst_busy",   32'(busy),            0);
        chk("rst_count",  32'(underrun_count),  0);
        chk("rst_sticky", 32'(underrun_sticky), 0);
        rst_n_240m_tx = 1'b1;
        step();
        chk("post_rst_ready", 32'(word_in_ready), 1);

        // words accepted in IDLE, no serial activity
        push(10'h2AA);
        push(10'h155);
        chk("idle_level", 32'(fifo_level),      2);
        chk("idle_busy",  32'(busy),            0);
        chk("idle_valid", 32'(tx_serial_valid), 0);

        // PRIME then RUN: 20 gap-free data bits
        tx_en = 1'b1;
        step();
        chk("prime_busy",  32'(busy),            1);
        chk("prime_valid", 32'(tx_serial_valid), 0);
        step();
        chk("load_level", 32'(fifo_level),      1);
        chk("load_valid", 32'(tx_serial_valid), 0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("run_bit",   32'(tx_serial_data),  32'(exp2[i]));
            chk("run_valid", 32'(tx_serial_valid), 1);
            chk("run_idle",  32'(tx_idle_pattern), 0);
        end
        chk("ur1_count",  32'(underrun_count),  1);
        chk("ur1_sticky", 32'(underrun_sticky), 1);

        // underrun fills with K28.5 RD-: 0011111010
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_bit",   32'(tx_serial_data),  32'(idlew[i]));
            chk("idle_flag",  32'(tx_idle_pattern), 1);
            chk("idle_valid", 32'(tx_serial_valid), 0);
        end
        chk("ur2_count", 32'(underrun_count), 2);

        // saturation: edge count k=30 here, k=3000 afterwards
        repeat (2970) step();
        chk("sat_count",  32'(underrun_count),  255);
        chk("sat_sticky", 32'(underrun_sticky), 1);
        // clear lands on a word boundary (k=3010), where an underrun also occurs
        repeat (9) step();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("clr_count",  32'(underrun_count),  0);
        chk("clr_sticky", 32'(underrun_sticky), 0);
        repeat (9) step();
        chk("clr_hold_count", 32'(underrun_count), 0);
        step();
        chk("post_clr_count", 32'(underrun_count), 1);

        // push during RUN, then drain mid-word
        push(w1);
        push(w2);
        push(10'h19E);
        chk("push_run_level", 32'(fifo_level), 3);
        repeat (7) step();
        chk("pop_level", 32'(fifo_level), 2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("w1_bit",   32'(tx_serial_data),  32'(w1[i]));
            chk("w1_valid", 32'(tx_serial_valid), 1);
        end
        tx_en = 1'b0;
        for (int i = 4; i < 10; i++) begin
            step();
            chk("drain_bit",   32'(tx_serial_data),  32'(w1[i]));
            chk("drain_valid", 32'(tx_serial_valid), 1);
        end
        chk("drain_end_busy", 32'(busy), 0);
        step();
        chk("drained_data",  32'(tx_serial_data),  0);
        chk("drained_valid", 32'(tx_serial_valid), 0);
        chk("drained_idle",  32'(tx_idle_pattern), 0);
        chk("drained_level", 32'(fifo_level),      2);
        chk("drained_count", 32'(underrun_count),  1);

        // fill to full; extra push refused
        push(10'h0AB);
        push(10'h350);
        chk("full_ready", 32'(word_in_ready), 0);
        push(10'h111);
        chk("full_level", 32'(fifo_level), 4);

        // restart from retained words, then reset mid-word
        tx_en = 1'b1;
        step();
        step();
        chk("restart_level", 32'(fifo_level),    3);
        chk("restart_ready", 32'(word_in_ready), 1);
        step();
        chk("w2_bit0", 32'(tx_serial_data), 32'(w2[0]));
        step();
        chk("w2_bit1", 32'(tx_serial_data), 32'(w2[1]));
        rst_n_240m_tx = 1'b0;
        #1;
        chk("abort_data",  32'(tx_serial_data),  0);
        chk("abort_valid", 32'(tx_serial_valid), 0);
        chk("abort_busy",  32'(busy),            0);
        chk("abort_level", 32'(fifo_level),      0);
        chk("abort_ready", 32'(word_in_ready),   0);
        tx_en = 1'b0;
        step();
        rst_n_240m_tx = 1'b1;
        step();
        chk("final_ready", 32'(word_in_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
